// File: rtl/id_ex_stage_if.sv
// Handshake and data bundle between fetch/writeback, the ID/EX stage and the ALU.
// The stage connects through the slave modport; its surroundings use master.
interface id_ex_stage_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned IDXW = 5
);
   logic            IF_VALID;
   logic [31:0]     IF_INSTR;
   logic [XLEN-1:0] IF_PC;
   logic            ID_READY;
   logic            EX_READY;
   logic            FLUSH;
   logic            WB_EN;
   logic [IDXW-1:0] WB_RD;
   logic [XLEN-1:0] WB_DATA;
   logic            EX_VALID;
   logic [XLEN-1:0] RS1_DATA;
   logic [XLEN-1:0] RS2_DATA;
   logic [XLEN-1:0] PC;
   logic [19:0]     U_IMM20;
   logic [11:0]     IMM12;
   logic [4:0]      RS2;
   logic [4:0]      RD;
   logic [6:0]      OPCODE;
   logic [2:0]      FUNCT3;
   logic            FUNCT1;

   modport slave (
      input  IF_VALID, IF_INSTR, IF_PC, EX_READY, FLUSH, WB_EN, WB_RD, WB_DATA,
      output ID_READY, EX_VALID, RS1_DATA, RS2_DATA, PC, U_IMM20, IMM12, RS2, RD,
             OPCODE, FUNCT3, FUNCT1
   );

   modport master (
      output IF_VALID, IF_INSTR, IF_PC, EX_READY, FLUSH, WB_EN, WB_RD, WB_DATA,
      input  ID_READY, EX_VALID, RS1_DATA, RS2_DATA, PC, U_IMM20, IMM12, RS2, RD,
             OPCODE, FUNCT3, FUNCT1
   );
endinterface

// File: rtl/id_ex_stage.sv
// RV32I decode/register-read stage: register file plus ID/EX pipeline register.
// Define RF_BYPASS_EN to make same-cycle writeback visible to the accepting read.
module id_ex_stage #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32
) (
   input logic          CLK,
   input logic          RST,
   id_ex_stage_if.slave bus
);
   localparam int unsigned IdxW = $clog2(NREG);

   logic [XLEN-1:0] rf_q [NREG];

   logic            ex_valid_q;
   logic [XLEN-1:0] rs1_data_q, rs2_data_q, pc_q;
   logic [19:0]     u_imm20_q;
   logic [11:0]     imm12_q;
   logic [IdxW-1:0] rs1_q, rs2_q;
   logic [4:0]      rd_q;
   logic [6:0]      opcode_q;
   logic [2:0]      funct3_q;
   logic            funct1_q;

   logic            id_ready;
   logic            accept;
   logic            wb_hit;
   logic [IdxW-1:0] rs1_idx, rs2_idx;
   logic [XLEN-1:0] rs1_rd, rs2_rd;
   logic [11:0]     imm12;

   always_comb begin
      id_ready = !ex_valid_q || bus.EX_READY;
      accept   = bus.IF_VALID && id_ready && !bus.FLUSH;
      wb_hit   = bus.WB_EN && (bus.WB_RD != '0);
      rs1_idx  = bus.IF_INSTR[15 +: IdxW];
      rs2_idx  = bus.IF_INSTR[20 +: IdxW];
      rs1_rd   = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
      rs2_rd   = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];
`ifdef RF_BYPASS_EN
      if (wb_hit && (bus.WB_RD == rs1_idx)) rs1_rd = bus.WB_DATA;
      if (wb_hit && (bus.WB_RD == rs2_idx)) rs2_rd = bus.WB_DATA;
`endif
      unique case (bus.IF_INSTR[6:0])
         7'b0100011: imm12 = {bus.IF_INSTR[31:25], bus.IF_INSTR[11:7]};
         7'b1100011: imm12 = {bus.IF_INSTR[31], bus.IF_INSTR[7], bus.IF_INSTR[30:25],
                              bus.IF_INSTR[11:8]};
         default:    imm12 = bus.IF_INSTR[31:20];
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (wb_hit) begin
         rf_q[bus.WB_RD] <= bus.WB_DATA;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ex_valid_q <= 1'b0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         pc_q       <= '0;
         u_imm20_q  <= '0;
         imm12_q    <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         opcode_q   <= '0;
         funct3_q   <= '0;
         funct1_q   <= 1'b0;
      end else if (accept) begin
         ex_valid_q <= 1'b1;
         rs1_data_q <= rs1_rd;
         rs2_data_q <= rs2_rd;
         pc_q       <= bus.IF_PC;
         u_imm20_q  <= bus.IF_INSTR[31:12];
         imm12_q    <= imm12;
         rs1_q      <= rs1_idx;
         rs2_q      <= rs2_idx;
         rd_q       <= bus.IF_INSTR[11:7];
         opcode_q   <= bus.IF_INSTR[6:0];
         funct3_q   <= bus.IF_INSTR[14:12];
         funct1_q   <= bus.IF_INSTR[30];
      end else begin
         if (bus.FLUSH || bus.EX_READY) ex_valid_q <= 1'b0;
         // A held instruction must not carry stale operands once writeback updates its sources
         if (ex_valid_q && !bus.EX_READY && wb_hit) begin
            if (bus.WB_RD == rs1_q) rs1_data_q <= bus.WB_DATA;
            if (bus.WB_RD == rs2_q) rs2_data_q <= bus.WB_DATA;
         end
      end
   end

   assign bus.ID_READY = id_ready;
   assign bus.EX_VALID = ex_valid_q;
   assign bus.RS1_DATA = rs1_data_q;
   assign bus.RS2_DATA = rs2_data_q;
   assign bus.PC       = pc_q;
   assign bus.U_IMM20  = u_imm20_q;
   assign bus.IMM12    = imm12_q;
   assign bus.RS2      = rs2_q;
   assign bus.RD       = rd_q;
   assign bus.OPCODE   = opcode_q;
   assign bus.FUNCT3   = funct3_q;
   assign bus.FUNCT1   = funct1_q;
endmodule
